dp_operand_sequencer: RTL and testbench

DP_OPERAND_SEQUENCER -- requirements
Module: dp_operand_sequencer

---
 rtl/dp_operand_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dp_operand_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_operand_sequencer.sv
// Operand sequencer for a dot-product accelerator: streams buffered
// operand pairs one element at a time and captures the final result.
module dp_operand_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        WR_EN,
    input  logic [3:0]  WR_ADDR,
    input  logic [7:0]  WR_A,
    input  logic [7:0]  WR_B,
    input  logic [4:0]  VEC_LEN,
    input  logic        CMD_START,
    output logic [7:0]  DP_A,
    output logic [7:0]  DP_B,
    output logic        inputs_ready,
    output logic        DP_START,
    input  logic        DP_DONE,
    input  logic [31:0] DP_RESULT,
    output logic [31:0] RESULT,
    output logic        RESULT_VALID,
    output logic        BUSY,
    output logic        ERR
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        CAPTURE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0]   opbuf [DEPTH];
    logic [IW-1:0] idx_q;
    logic [4:0]    len_q;
    logic [TW-1:0] tmo_q;

    logic len_ok;
    logic last;
    logic expired;
    logic wr_ok;

    assign len_ok  = (VEC_LEN != 5'd0) && (32'(VEC_LEN) <= DEPTH);
    assign last    = (32'(idx_q) + 32'd1) == 32'(len_q);
    assign expired = 32'(tmo_q) >= (TIMEOUT - 1);
    assign wr_ok   = WR_EN && (state_q == IDLE) && (32'(WR_ADDR) < DEPTH);

    // Operand storage survives reset; software reloads it explicitly.
    always_ff @(posedge ACLK) begin
        if (wr_ok) begin
            opbuf[WR_ADDR[IW-1:0]] <= {WR_A, WR_B};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (CMD_START && len_ok) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (DP_DONE) begin
                    state_d = last ? CAPTURE : ISSUE;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            idx_q        <= '0;
            len_q        <= '0;
            tmo_q        <= '0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            RESULT_VALID <= 1'b0;
            ERR          <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (CMD_START) begin
                        if (len_ok) begin
                            len_q <= VEC_LEN;
                            idx_q <= '0;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    tmo_q <= '0;
                end
                WAIT_DONE: begin
                    if (DP_DONE) begin
                        if (!last) begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else if (expired) begin
                        ERR <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                CAPTURE: begin
                    RESULT       <= DP_RESULT;
                    RESULT_VALID <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ISSUE always hands over to WAIT_DONE, so inputs_ready is never
    // asserted on two adjacent cycles.
    always_comb begin
        BUSY         = 1'b0;
        inputs_ready = 1'b0;
        DP_START     = 1'b0;
        DP_A         = '0;
        DP_B         = '0;
        unique case (state_q)
            IDLE: begin
            end
            ISSUE: begin
                BUSY         = 1'b1;
                inputs_ready = 1'b1;
                DP_START     = last;
                DP_A         = opbuf[idx_q][15:8];
                DP_B         = opbuf[idx_q][7:0];
            end
            WAIT_DONE: begin
                BUSY     = 1'b1;
                DP_START = last;
                DP_A     = opbuf[idx_q][15:8];
                DP_B     = opbuf[idx_q][7:0];
            end
            CAPTURE: begin
                BUSY = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dp_operand_sequencer.sv
// Bench for dp_operand_sequencer: accelerator model plus table-driven,
// hand-written and randomized runs against a dot-product reference.
module tb_dp_operand_sequencer;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 15;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        WR_EN;
    logic [3:0]  WR_ADDR;
    logic [7:0]  WR_A;
    logic [7:0]  WR_B;
    logic [4:0]  VEC_LEN;
    logic        CMD_START;
    logic [7:0]  DP_A;
    logic [7:0]  DP_B;
    logic        inputs_ready;
    logic        DP_START;
    logic        DP_DONE;
    logic [31:0] DP_RESULT;
    logic [31:0] RESULT;
    logic        RESULT_VALID;
    logic        BUSY;
    logic        ERR;

    dp_operand_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR),
        .WR_A(WR_A),
        .WR_B(WR_B),
        .VEC_LEN(VEC_LEN),
        .CMD_START(CMD_START),
        .DP_A(DP_A),
        .DP_B(DP_B),
        .inputs_ready(inputs_ready),
        .DP_START(DP_START),
        .DP_DONE(DP_DONE),
        .DP_RESULT(DP_RESULT),
        .RESULT(RESULT),
        .RESULT_VALID(RESULT_VALID),
        .BUSY(BUSY),
        .ERR(ERR)
    );

    always #5 ACLK = ~ACLK;

    // Accelerator: accumulates a*b on each operand-valid pulse and
    // acknowledges one cycle later when responding.
    logic [31:0] acc = 32'd0;
    logic        acc_clr = 1'b0;
    logic        respond = 1'b1;

    initial DP_DONE = 1'b0;
    assign DP_RESULT = acc;

    always @(posedge ACLK) begin
        if (acc_clr) acc <= 32'd0;
        else if (inputs_ready) acc <= acc + 32'(DP_A) * 32'(DP_B);
        DP_DONE <= inputs_ready && respond;
    end

    int checks = 0;
    int errors = 0;
    int b2b    = 0;
    logic prev_ir = 1'b0;

    always @(negedge ACLK) begin
        if (prev_ir && inputs_ready) b2b++;
        prev_ir = inputs_ready;
    end

    logic [7:0]  sa [DEPTH];
    logic [7:0]  sb [DEPTH];
    logic [31:0] prev_result = 32'd0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] a, input logic [7:0] b);
        WR_EN   = 1'b1;
        WR_ADDR = 4'(addr);
        WR_A    = a;
        WR_B    = b;
        @(posedge ACLK);
        #1;
        WR_EN = 1'b0;
        sa[addr] = a;
        sb[addr] = b;
    endtask

    task automatic run(input int len, input bit rsp, input int rst_at,
                       input bit poke, input bit sw, input logic [7:0] swa,
                       input logic [7:0] swb, input int exp_rv,
                       input int exp_err, input int exp_issues);
        int k = 0;
        int rv_c = -1;
        int err_c = -1;
        int extra = 0;
        bit done = 0;
        bit busy_end = 0;
        bit normal;
        logic [31:0] exp_sum = 32'd0;
        respond = rsp;
        acc_clr = 1'b1;
        @(posedge ACLK);
        #1;
        acc_clr = 1'b0;
        if (sw) begin
            WR_EN = 1'b1; WR_ADDR = 4'd0; WR_A = swa; WR_B = swb;
            sa[0] = swa; sb[0] = swb;
        end
        for (int i = 0; i < len && i < DEPTH; i++)
            exp_sum += 32'(sa[i]) * 32'(sb[i]);
        normal = rsp && rst_at == 0 && len >= 1 && len <= DEPTH;
        VEC_LEN   = 5'(len);
        CMD_START = 1'b1;
        for (int c = 1; c <= 80 && !done; c++) begin
            @(posedge ACLK);
            #1;
            CMD_START = poke && c == 3;
            WR_EN     = poke && c == 3;
            WR_ADDR   = 4'd1;
            WR_A      = 8'hEE;
            WR_B      = 8'hEE;
            ARESET    = (rst_at > 0 && c == rst_at);
            @(negedge ACLK);
            if (rst_at > 0 && c == rst_at + 1) begin
                chk("rst_dp_a", DP_A, 0);
                chk("rst_dp_b", DP_B, 0);
                chk("rst_ready", inputs_ready, 0);
                chk("rst_dp_start", DP_START, 0);
                chk("rst_busy", BUSY, 0);
                chk("rst_result", RESULT, 0);
                chk("rst_rv", RESULT_VALID, 0);
                chk("rst_err", ERR, 0);
                done = 1;
            end else begin
                if (normal && c <= 2 * len)
                    chk("dp_start_cyc", DP_START, ((c - 1) / 2 == len - 1));
                if (normal && c <= 2 * len + 1)
                    chk("busy_cyc", BUSY, 1);
                if (inputs_ready) begin
                    chk("issue_cycle", c, 2 * k + 1);
                    if (k < DEPTH) begin
                        chk("dp_a", DP_A, sa[k]);
                        chk("dp_b", DP_B, sb[k]);
                    end
                    chk("issue_dp_start", DP_START, (k == len - 1));
                    k++;
                end
                if (RESULT_VALID) begin rv_c = c; done = 1; end
                if (ERR) begin err_c = c; done = 1; end
                busy_end = BUSY;
            end
        end
        CMD_START = 1'b0;
        WR_EN     = 1'b0;
        ARESET    = 1'b0;
        chk("run_bound", done, 1);
        chk("rv_cycle", rv_c, exp_rv);
        chk("err_cycle", err_c, exp_err);
        chk("issues", k, exp_issues);
        if (rst_at > 0) begin
            prev_result = 32'd0;
        end else if (exp_rv > 0) begin
            chk("result", RESULT, exp_sum);
            chk("busy_end", busy_end, 0);
            prev_result = exp_sum;
        end else begin
            chk("result_hold", RESULT, prev_result);
            chk("busy_end", busy_end, 0);
        end
        repeat (4) begin
            @(posedge ACLK);
            #1;
            @(negedge ACLK);
            if (RESULT_VALID || ERR || inputs_ready || BUSY) extra++;
        end
        chk("quiet_after", extra, 0);
    endtask

    typedef struct {
        int len;
        bit rsp;
        int rst_at;
        bit poke;
        int exp_rv;
        int exp_err;
        int exp_issues;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{3,  1, 0, 0,  8, -1, 3};
        tbl[1] = '{0,  1, 0, 0, -1,  1, 0};
        tbl[2] = '{17, 1, 0, 0, -1,  1, 0};
        tbl[3] = '{31, 1, 0, 0, -1,  1, 0};
        tbl[4] = '{3,  0, 0, 0, -1, 2 + TIMEOUT, 1};
        tbl[5] = '{3,  1, 4, 0, -1, -1, 2};
        tbl[6] = '{3,  1, 0, 0,  8, -1, 3};
        tbl[7] = '{3,  1, 0, 1,  8, -1, 3};
        tbl[8] = '{3,  1, 0, 0,  8, -1, 3};

        ARESET = 1'b1; WR_EN = 1'b0; WR_ADDR = 4'd0; WR_A = 8'd0;
        WR_B = 8'd0; VEC_LEN = 5'd0; CMD_START = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_dp_a", DP_A, 0);
        chk("reset_dp_b", DP_B, 0);
        chk("reset_ready", inputs_ready, 0);
        chk("reset_dp_start", DP_START, 0);
        chk("reset_result", RESULT, 0);
        chk("reset_rv", RESULT_VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_err", ERR, 0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        wr(0, 8'd2, 8'd3);
        wr(1, 8'd4, 8'd5);
        wr(2, 8'd6, 8'd7);

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].len, tbl[i].rsp, tbl[i].rst_at, tbl[i].poke,
                1'b0, 8'd0, 8'd0,
                tbl[i].exp_rv, tbl[i].exp_err, tbl[i].exp_issues);
            if (tbl[i].exp_rv > 0) chk("result_68", RESULT, 68);
        end

        for (int i = 0; i < DEPTH; i++) wr(i, 8'd255, 8'd255);
        run(16, 1'b1, 0, 1'b0, 1'b0, 8'd0, 8'd0, 34, -1, 16);
        chk("result_full", RESULT, 1040400);

        run(1, 1'b1, 0, 1'b0, 1'b1, 8'd9, 8'd9, 4, -1, 1);
        chk("result_same_cycle_wr", RESULT, 81);

        for (int t = 0; t < 12; t++) begin
            int n;
            int nw;
            nw = $urandom_range(1, 8);
            for (int j = 0; j < nw; j++)
                wr($urandom_range(0, DEPTH - 1), 8'($urandom), 8'($urandom));
            n = $urandom_range(1, DEPTH);
            run(n, 1'b1, 0, 1'b0, 1'b0, 8'd0, 8'd0, 2 * n + 2, -1, n);
        end

        chk("no_back_to_back_ready", b2b, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
